// File: rtl/regbank_write_arbiter_if.sv
// Write-request bus between the two requesters / clear controller and the
// arbiter, plus the registered register-bank write port.
interface regbank_write_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic [3:0]        a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [3:0]        b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              clr_start;
    logic              clr_busy;
    logic [15:0]       en;
    logic [DATA_W-1:0] R;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_start,
        input  a_ready, b_ready, clr_busy, en, R
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_start,
        output a_ready, b_ready, clr_busy, en, R
    );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Two-requester round-robin write arbiter for a 16-entry register bank,
// with a sequential clear that walks every register once.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | arbitrating A/B writes; clr_start launches a clear
// S_CLEAR | issuing clear writes to registers 0..15, requesters stalled
module regbank_write_arbiter #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    regbank_write_arbiter_if.slave  bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              r_favor_b;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_accept;
    logic [3:0]        w_addr;
    logic [DATA_W-1:0] w_data;
    logic [15:0]       r_en;
    logic [DATA_W-1:0] r_wdata;

    // Next state, clear counter and grants; clr_start outranks any valid.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        w_cnt_nxt   = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    if (bus.clr_start) begin
                        w_state_nxt = S_CLEAR;
                    end else if (bus.a_valid && bus.b_valid) begin
                        w_grant_a = !r_favor_b;
                        w_grant_b = r_favor_b;
                    end else begin
                        w_grant_a = bus.a_valid;
                        w_grant_b = bus.b_valid;
                    end
                end
            end
            S_CLEAR: begin
                // Counter wraps to 0 naturally as the last register is left.
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_accept = w_grant_a || w_grant_b;
        w_addr   = w_grant_b ? bus.b_addr : bus.a_addr;
        w_data   = w_grant_b ? bus.b_data : bus.a_data;
    end

    // State, counter and round-robin pointer; pointer moves only on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_favor_b <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_favor_b <= w_grant_a;
            end
        end
    end

    // Registered bank write port: clear write, accepted write, or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en    <= 16'h0000;
            r_wdata <= '0;
        end else if (w_state_nxt == S_CLEAR) begin
            r_en    <= 16'h0001 << w_cnt_nxt;
            r_wdata <= CLEAR_VAL;
        end else if (w_accept) begin
            r_en    <= 16'h0001 << w_addr;
            r_wdata <= w_data;
        end else begin
            r_en    <= 16'h0000;
        end
    end

    assign bus.a_ready  = w_grant_a;
    assign bus.b_ready  = w_grant_b;
    assign bus.clr_busy = (r_state == S_CLEAR);
    assign bus.en       = r_en;
    assign bus.R        = r_wdata;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a
// behavioural model.
module tb_regbank_write_arbiter;

    localparam int          DATA_W = 32;
    localparam logic [31:0] CLR_V  = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regbank_write_arbiter_if #(.DATA_W(DATA_W)) bus ();

    regbank_write_arbiter #(.DATA_W(DATA_W), .CLEAR_VAL(CLR_V)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: clear position (-1 when not clearing), who is
    // favoured on contention, and the expected write-port contents.
    int          m_clr_pos  = -1;
    logic        m_favor_a  = 1'b1;
    logic [15:0] m_en       = '0;
    logic [31:0] m_R        = '0;
    logic        m_acc      = 1'b0;
    logic        m_acc_b    = 1'b0;
    logic [3:0]  m_acc_addr = '0;
    logic [31:0] m_acc_data = '0;
    logic        mon_en     = 1'b0;
    logic        acc_a_seen = 1'b0;
    logic        acc_b_seen = 1'b0;

    // Model update at each clock edge.
    always @(posedge clk) begin
        if (rst) begin
            m_en      <= '0;
            m_R       <= '0;
            m_clr_pos <= -1;
            m_favor_a <= 1'b1;
        end else if (m_clr_pos >= 0) begin
            if (m_clr_pos < 15) begin
                m_clr_pos <= m_clr_pos + 1;
                m_en      <= 16'h0001 << (m_clr_pos + 1);
                m_R       <= CLR_V;
            end else begin
                m_clr_pos <= -1;
                m_en      <= '0;
            end
        end else if (bus.clr_start) begin
            m_clr_pos <= 0;
            m_en      <= 16'h0001;
            m_R       <= CLR_V;
        end else if (m_acc) begin
            m_en      <= 16'h0001 << m_acc_addr;
            m_R       <= m_acc_data;
            m_favor_a <= m_acc_b;
        end else begin
            m_en      <= '0;
        end
    end

    // Single compare process: outputs checked mid-cycle against the model.
    always @(negedge clk) begin
        logic ea, eb;
        if (mon_en) begin
            ea = 1'b0;
            eb = 1'b0;
            if (!rst && m_clr_pos < 0 && !bus.clr_start) begin
                if (bus.a_valid && bus.b_valid) begin
                    ea = m_favor_a;
                    eb = !m_favor_a;
                end else begin
                    ea = bus.a_valid;
                    eb = bus.b_valid;
                end
            end
            chk("a_ready", bus.a_ready, ea);
            chk("b_ready", bus.b_ready, eb);
            chk("en", bus.en, m_en);
            chk("R", bus.R, m_R);
            chk("clr_busy", bus.clr_busy, m_clr_pos >= 0);
            chk("en_onehot", $countones(bus.en) <= 1, 1'b1);
            m_acc      = ea | eb;
            m_acc_b    = eb;
            m_acc_addr = eb ? bus.b_addr : bus.a_addr;
            m_acc_data = eb ? bus.b_data : bus.a_data;
            acc_a_seen = bus.a_valid && bus.a_ready;
            acc_b_seen = bus.b_valid && bus.b_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.a_valid   = 1'b0;
        bus.a_addr    = '0;
        bus.a_data    = '0;
        bus.b_valid   = 1'b0;
        bus.b_addr    = '0;
        bus.b_data    = '0;
        bus.clr_start = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_en", bus.en, 16'h0);
        chk("rst_R", bus.R, 32'h0);
        chk("rst_busy", bus.clr_busy, 1'b0);

        // Single write.
        bus.a_valid = 1'b1; bus.a_addr = 4'd5; bus.a_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("single_ready", bus.a_ready, 1'b1);
        tick();
        bus.a_valid = 1'b0;
        @(negedge clk);
        chk("single_en", bus.en, 16'h0020);
        chk("single_R", bus.R, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("single_en_off", bus.en, 16'h0);

        // Contention right after reset: A, B, A, B.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.a_valid = 1'b1; bus.a_addr = 4'd1; bus.a_data = 32'hA;
        bus.b_valid = 1'b1; bus.b_addr = 4'd2; bus.b_data = 32'hB;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_a_ready", bus.a_ready, (i % 2) == 0);
            if (i > 0) chk("rr_en", bus.en, (i % 2) == 1 ? 16'h0002 : 16'h0004);
            tick();
        end

        // Write at N-1, clear at N, clr_start re-pulsed at N+5.
        bus.b_valid = 1'b0;
        bus.a_addr = 4'd3; bus.a_data = 32'h1234;
        @(negedge clk);
        chk("rr_en_last", bus.en, 16'h0004);
        chk("pre_clr_ready", bus.a_ready, 1'b1);
        tick();
        bus.clr_start = 1'b1;
        @(negedge clk);
        chk("clr_n_ready", bus.a_ready, 1'b0);
        chk("clr_n_en", bus.en, 16'h0008);
        chk("clr_n_R", bus.R, 32'h1234);
        chk("clr_n_busy", bus.clr_busy, 1'b0);
        tick();
        bus.clr_start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("clr_en", bus.en, 16'h0001 << (k - 1));
            chk("clr_R", bus.R, 32'h0);
            chk("clr_busy", bus.clr_busy, 1'b1);
            chk("clr_ready", bus.a_ready, 1'b0);
            tick();
            bus.clr_start = (k == 4);
        end
        @(negedge clk);
        chk("post_clr_ready", bus.a_ready, 1'b1);
        chk("post_clr_busy", bus.clr_busy, 1'b0);
        chk("post_clr_en", bus.en, 16'h0);
        tick();
        bus.a_valid = 1'b0;
        @(negedge clk);
        chk("post_clr_wr_en", bus.en, 16'h0008);
        chk("post_clr_wr_R", bus.R, 32'h1234);

        // Reset in the middle of a clear.
        tick();
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("mid_clr_en", bus.en, 16'h0001 << (k - 1));
            tick();
            if (k == 7) rst = 1'b1;
        end
        rst = 1'b0;
        bus.a_valid = 1'b1; bus.a_addr = 4'd7; bus.a_data = 32'h77;
        bus.b_valid = 1'b1; bus.b_addr = 4'd9; bus.b_data = 32'h99;
        @(negedge clk);
        chk("abort_en", bus.en, 16'h0);
        chk("abort_busy", bus.clr_busy, 1'b0);
        chk("abort_R", bus.R, 32'h0);
        chk("abort_a_ready", bus.a_ready, 1'b1);
        chk("abort_b_ready", bus.b_ready, 1'b0);
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;

        // Randomized traffic; pending requests hold until accepted.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(299) == 0);
            bus.clr_start = ($urandom_range(49) == 0);
            if (!bus.a_valid || acc_a_seen) begin
                bus.a_valid = ($urandom_range(2) != 0);
                bus.a_addr  = 4'($urandom_range(15));
                bus.a_data  = $urandom;
            end
            if (!bus.b_valid || acc_b_seen) begin
                bus.b_valid = ($urandom_range(2) != 0);
                bus.b_addr  = 4'($urandom_range(15));
                bus.b_data  = $urandom;
            end
        end
        tick();
        rst = 1'b0;
        bus.clr_start = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_write_arbiter.md
REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have DATA_W, default 32: width of write data and of R.
REQ-002 The block SHALL have CLEAR_VAL, default 0: value written to every register during a clear sequence.
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have a_valid, input, 1: requester A has a write pending.
REQ-006 The block SHALL have a_addr, input, 4: requester A target register index, 0-15.
REQ-007 The block SHALL have a_data, input, DATA_W: requester A write data.
REQ-008 The block SHALL have a_ready, output, 1: requester A write accepted this cycle.
REQ-009 The block SHALL have b_valid, input, 1: requester B has a write pending.
REQ-010 The block SHALL have b_addr, input, 4: requester B target register index, 0-15.
REQ-011 The block SHALL have b_data, input, DATA_W: requester B write data.
REQ-012 The block SHALL have b_ready, output, 1: requester B write accepted this cycle.
REQ-013 The block SHALL have clr_start, input, 1: start a sequential clear of all 16 registers.
REQ-014 The block SHALL have clr_busy, output, 1: a clear sequence is in progress.
REQ-015 The block SHALL have en, output, 16: one-hot register-bank write enable, registered; all-zero means no write.
REQ-016 The block SHALL have R, output, DATA_W: register-bank write data, registered.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and CLEAR.
REQ-018 A write is accepted in a cycle when valid and ready are both high; a_ready and b_ready SHALL be combinational and never high together.
REQ-019 In IDLE with clr_start low, the arbiter SHALL grant a sole valid requester; when both requesters are valid, it SHALL grant the one not granted most recently (round-robin).
REQ-020 The round-robin pointer SHALL update only on an acceptance.
REQ-021 An acceptance in cycle N SHALL produce en = 1<<addr and R = data in cycle N+1, for exactly one cycle; latency is 1 cycle; throughput is one write per cycle.
REQ-022 In any cycle with no acceptance and no clear write, en SHALL be 16'h0000 in the following cycle and R SHALL hold its last value.
REQ-023 clr_start high in IDLE SHALL force a_ready = b_ready = 0 in that same cycle and move the FSM to CLEAR; clr_start has priority over simultaneous valids.
REQ-024 A write accepted in the cycle before clr_start SHALL still issue normally, in the cycle in which clr_start is high.
REQ-025 In CLEAR, a 4-bit counter starting at 0 SHALL drive en = 1<<count and R = CLEAR_VAL on clock cycles N+1..N+16 (N = clr_start cycle), incrementing once per cycle.
REQ-026 clr_busy SHALL be high on cycles N+1..N+16 inclusive; a_ready and b_ready SHALL be 0 throughout CLEAR.
REQ-027 After count 15 is issued, the FSM SHALL return to IDLE and the counter SHALL wrap to 0; acceptances resume on cycle N+17.
REQ-028 clr_start asserted while in CLEAR SHALL be ignored; it neither restarts nor extends the sequence.
REQ-029 Valid inputs held while ready is low SHALL remain pending; the block SHALL never drop or duplicate an accepted write.
REQ-030 en SHALL never have more than one bit set.

Reset
REQ-031 When rst is high at a clock edge, the block SHALL set the FSM to IDLE, the counter to 0, and en to 0, R to 0, and clr_busy to 0, and SHALL set the round-robin pointer to favor A.
REQ-032 rst SHALL override clr_start and any acceptance in the same cycle; a reset during CLEAR SHALL abort the sequence with no further enables.
REQ-033 While rst is high, a_ready and b_ready SHALL be 0.

Verification
REQ-034 Single write: a_valid=1, a_addr=5, a_data=32'hDEADBEEF for one cycle -> a_ready=1 in that cycle; next cycle en=16'h0020, R=32'hDEADBEEF; the cycle after, en=0.
REQ-035 Contention: both valid every cycle after reset (a_addr=1, b_addr=2) -> grants go A, B, A, B; en sequence is 0x0002, 0x0004, 0x0002, 0x0004.
REQ-036 Clear: clr_start pulse at cycle N with a_valid held -> a_ready=0 on cycles N..N+16; en=0x0001..0x8000 with R=0 on cycles N+1..N+16; clr_busy high on cycles N+1..N+16; A is accepted at N+17.
REQ-037 Simultaneous events: a write accepted at N-1 and clr_start at N -> the write issues at N and the clear writes follow at N+1..N+16; clr_start re-pulsed at N+5 -> no change to the sequence.
REQ-038 Reset mid-clear: rst at cycle N+8 -> at N+9, en=0, clr_busy=0, R=0, FSM in IDLE; a subsequent simultaneous A/B request grants A.
REQ-039 Random stimulus with scoreboard -> every accepted (addr, data) pair appears exactly once, in order, on en/R; en is always one-hot or zero.
